// File: rtl/dly_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// dly_cmd_sequencer
//   Host-side command front end for the delay address controller. Takes one
//   LOAD / INC / DEC / READ command at a time over valid/ready, expands it into
//   registered one-hot usr_dly_* strobes with the required setup/hold timing,
//   and returns a single-cycle response (READ carries the sampled lane tap).
//
// Ports
//   clk                   in   rising-edge clock
//   rst                   in   synchronous, active-low reset
//   cmd_valid/cmd_ready   in/out  command handshake (ready only when idle)
//   cmd_op                in   0=LOAD 1=INC 2=DEC 3=READ
//   cmd_idx               in   target lane
//   rsp_valid             out  one-cycle response strobe, no backpressure
//   rsp_err               out  lane out of range or masked off
//   rsp_idx               out  lane of the completed command
//   rsp_tap               out  sampled tap value (READ only, else 0)
//   busy                  out  sequencer not idle
//   usr_dly_incdec        out  one-hot increment/decrement level
//   usr_dly_ld            out  one-hot load strobe
//   usr_dly_adj           out  one-hot adjust strobe
//   usr_rd_dly_value      out  one-hot read request
//   usr_dly_tap_value_in  in   controller tap bus, lane i at [i*W +: W]
// -----------------------------------------------------------------------------
module dly_cmd_sequencer #(
   parameter int          NUM_DLY_PORTS  = 20,
   parameter int          DLY_TAP_WIDTH  = 6,
   parameter logic [19:0] DLY_VALID_MASK = 20'hFFFFF,
   parameter int          SETUP_CYC      = 1,
   parameter int          HOLD_CYC       = 2,
   parameter int          RD_WAIT_CYC    = 3,
   localparam int         MAX_PORTS      = 20
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [1:0]                           cmd_op,
   input  logic [4:0]                           cmd_idx,
   output logic                                 rsp_valid,
   output logic                                 rsp_err,
   output logic [4:0]                           rsp_idx,
   output logic [DLY_TAP_WIDTH-1:0]             rsp_tap,
   output logic                                 busy,
   output logic [MAX_PORTS-1:0]                 usr_dly_incdec,
   output logic [MAX_PORTS-1:0]                 usr_dly_ld,
   output logic [MAX_PORTS-1:0]                 usr_dly_adj,
   output logic [MAX_PORTS-1:0]                 usr_rd_dly_value,
   input  logic [MAX_PORTS*DLY_TAP_WIDTH-1:0]   usr_dly_tap_value_in
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_RD_WAIT, S_RESP
   } state_e;

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0, OP_INC = 2'd1, OP_DEC = 2'd2, OP_READ = 2'd3
   } op_e;

   localparam int CNT_W = 8;
   // Lanes that physically exist and are enabled; indices 20..31 are always 0.
   localparam logic [31:0] LANE_OK =
      32'(DLY_VALID_MASK) & ((32'd1 << NUM_DLY_PORTS) - 32'd1);
   // Counters are loaded with (cycles - 1) and the state exits on zero.
   localparam int RD_CYC = (RD_WAIT_CYC < 1) ? 1 : RD_WAIT_CYC;
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_CYC - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   op_e                     op_q;
   logic [4:0]              idx_q;
   logic                    err_q;
   logic                    ready_q;

   logic [MAX_PORTS-1:0]    incdec_q, incdec_d;
   logic [MAX_PORTS-1:0]    ld_q, ld_d;
   logic [MAX_PORTS-1:0]    adj_q, adj_d;
   logic [MAX_PORTS-1:0]    rd_q, rd_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    rsp_err_q, rsp_err_d;
   logic [4:0]              rsp_idx_q, rsp_idx_d;
   logic [DLY_TAP_WIDTH-1:0] rsp_tap_q, rsp_tap_d;

   logic                    accept;
   logic                    cmd_err;
   op_e                     op_n;
   logic [4:0]              idx_n;
   logic                    err_n;
   logic [MAX_PORTS-1:0]    lane_oh;
   logic [DLY_TAP_WIDTH-1:0] tap_slice;

   // ready_q is only ever set while idle, so it alone qualifies the accept.
   assign accept  = cmd_valid & ready_q;
   assign cmd_err = ~LANE_OK[cmd_idx];

   // Outputs are registered from the next state, so the command fields must
   // be visible in the accept cycle before op_q/idx_q are loaded.
   assign op_n  = accept ? op_e'(cmd_op) : op_q;
   assign idx_n = accept ? cmd_idx       : idx_q;
   assign err_n = accept ? cmd_err       : err_q;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of statement order.
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_LOAD;
         idx_q   <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == S_IDLE);
         if (accept) begin
            op_q  <= op_e'(cmd_op);
            idx_q <= cmd_idx;
            err_q <= cmd_err;
         end
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      // NOTE: every variable driven here gets a default first, otherwise a
      // path that skips the assignment would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (cmd_err) begin
                  state_d = S_RESP;
               end else begin
                  unique case (op_e'(cmd_op))
                     OP_LOAD: state_d = S_PULSE;
                     OP_INC, OP_DEC: begin
                        if (SETUP_CYC > 0) begin
                           state_d = S_SETUP;
                           cnt_d   = SETUP_LD;
                        end else begin
                           state_d = S_PULSE;
                        end
                     end
                     OP_READ: begin
                        state_d = S_RD_WAIT;
                        cnt_d   = RD_LD;
                     end
                  endcase
               end
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) state_d = S_PULSE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_PULSE: begin
            if (HOLD_CYC > 0) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               state_d = S_RESP;
            end
         end
         S_HOLD, S_RD_WAIT: begin
            if (cnt_q == '0) state_d = S_RESP;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      tap_slice = '0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (idx_q == 5'(i)) tap_slice = usr_dly_tap_value_in[i*DLY_TAP_WIDTH +: DLY_TAP_WIDTH];
      end

      lane_oh = '0;
      if (LANE_OK[idx_n]) lane_oh = (MAX_PORTS'(1) << idx_n) & LANE_OK[MAX_PORTS-1:0];

      incdec_d = '0;
      ld_d     = '0;
      adj_d    = '0;
      rd_d     = '0;
      if (op_n == OP_INC && state_d inside {S_SETUP, S_PULSE, S_HOLD}) incdec_d = lane_oh;
      if (state_d == S_PULSE) begin
         if (op_n == OP_LOAD) ld_d  = lane_oh;
         else                 adj_d = lane_oh;
      end
      if (state_d == S_RD_WAIT) rd_d = lane_oh;

      rsp_valid_d = (state_d == S_RESP);
      rsp_err_d   = rsp_valid_d & err_n;
      rsp_idx_d   = rsp_valid_d ? idx_n : '0;
      // Sample the lane on the edge that closes the last RD_WAIT cycle.
      rsp_tap_d   = (state_q == S_RD_WAIT && state_d == S_RESP) ? tap_slice : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         incdec_q    <= '0;
         ld_q        <= '0;
         adj_q       <= '0;
         rd_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_idx_q   <= '0;
         rsp_tap_q   <= '0;
      end else begin
         incdec_q    <= incdec_d;
         ld_q        <= ld_d;
         adj_q       <= adj_d;
         rd_q        <= rd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_idx_q   <= rsp_idx_d;
         rsp_tap_q   <= rsp_tap_d;
      end
   end

   assign cmd_ready        = ready_q;
   assign busy             = (state_q != S_IDLE);
   assign usr_dly_incdec   = incdec_q;
   assign usr_dly_ld       = ld_q;
   assign usr_dly_adj      = adj_q;
   assign usr_rd_dly_value = rd_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_err          = rsp_err_q;
   assign rsp_idx          = rsp_idx_q;
   assign rsp_tap          = rsp_tap_q;

endmodule

// File: tb/tb_dly_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dly_cmd_sequencer
//   Self-checking bench for dly_cmd_sequencer. Two instances: one with the
//   default lane mask and one with mask 20'h0C117; `sel` routes the shared
//   command inputs and the observed outputs to one of them. A vector table
//   drives single commands and checks every output cycle by cycle against a
//   timeline model; hand-written sequences cover reset, abort and back-to-back.
// -----------------------------------------------------------------------------
module tb_dly_cmd_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         sel;
   logic [1:0]   cmd_op;
   logic [4:0]   cmd_idx;
   logic [119:0] tap_bus;

   logic         vld_d, vld_m;
   assign vld_d = cmd_valid & ~sel;
   assign vld_m = cmd_valid &  sel;

   logic        d_ready, d_rv, d_rerr, d_busy;
   logic [4:0]  d_ridx;
   logic [5:0]  d_rtap;
   logic [19:0] d_incdec, d_ld, d_adj, d_rd;
   logic        m_ready, m_rv, m_rerr, m_busy;
   logic [4:0]  m_ridx;
   logic [5:0]  m_rtap;
   logic [19:0] m_incdec, m_ld, m_adj, m_rd;

   logic        o_ready, o_rv, o_rerr, o_busy;
   logic [4:0]  o_ridx;
   logic [5:0]  o_rtap;
   logic [19:0] o_incdec, o_ld, o_adj, o_rd;

   assign o_ready  = sel ? m_ready  : d_ready;
   assign o_rv     = sel ? m_rv     : d_rv;
   assign o_rerr   = sel ? m_rerr   : d_rerr;
   assign o_busy   = sel ? m_busy   : d_busy;
   assign o_ridx   = sel ? m_ridx   : d_ridx;
   assign o_rtap   = sel ? m_rtap   : d_rtap;
   assign o_incdec = sel ? m_incdec : d_incdec;
   assign o_ld     = sel ? m_ld     : d_ld;
   assign o_adj    = sel ? m_adj    : d_adj;
   assign o_rd     = sel ? m_rd     : d_rd;

   dly_cmd_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(vld_d), .cmd_ready(d_ready),
      .cmd_op(cmd_op), .cmd_idx(cmd_idx),
      .rsp_valid(d_rv), .rsp_err(d_rerr), .rsp_idx(d_ridx), .rsp_tap(d_rtap),
      .busy(d_busy), .usr_dly_incdec(d_incdec), .usr_dly_ld(d_ld),
      .usr_dly_adj(d_adj), .usr_rd_dly_value(d_rd),
      .usr_dly_tap_value_in(tap_bus)
   );

   dly_cmd_sequencer #(.DLY_VALID_MASK(20'h0C117)) dut_m (
      .clk(clk), .rst(rst), .cmd_valid(vld_m), .cmd_ready(m_ready),
      .cmd_op(cmd_op), .cmd_idx(cmd_idx),
      .rsp_valid(m_rv), .rsp_err(m_rerr), .rsp_idx(m_ridx), .rsp_tap(m_rtap),
      .busy(m_busy), .usr_dly_incdec(m_incdec), .usr_dly_ld(m_ld),
      .usr_dly_adj(m_adj), .usr_rd_dly_value(m_rd),
      .usr_dly_tap_value_in(tap_bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected outputs k cycles after the accept edge, default timing
   // (SETUP=1, HOLD=2, RD_WAIT=3).
   task automatic check_cycle(input string tag, input int k, input logic [1:0] op,
                              input logic [4:0] idx, input logic err, input int rsp_k,
                              input logic [5:0] exp_tap);
      logic [19:0] oh;
      logic [19:0] e_incdec, e_adj, e_ld, e_rd;
      logic        at_rsp;
      oh       = err ? 20'd0 : (20'd1 << idx);
      at_rsp   = (k == rsp_k);
      e_incdec = (!err && op == 2'd1 && k >= 1 && k <= 4) ? oh : 20'd0;
      e_adj    = (!err && (op == 2'd1 || op == 2'd2) && k == 2) ? oh : 20'd0;
      e_ld     = (!err && op == 2'd0 && k == 1) ? oh : 20'd0;
      e_rd     = (!err && op == 2'd3 && k >= 1 && k <= 3) ? oh : 20'd0;
      check($sformatf("%s k%0d incdec", tag, k), 32'(o_incdec), 32'(e_incdec));
      check($sformatf("%s k%0d adj", tag, k),    32'(o_adj),    32'(e_adj));
      check($sformatf("%s k%0d ld", tag, k),     32'(o_ld),     32'(e_ld));
      check($sformatf("%s k%0d rd", tag, k),     32'(o_rd),     32'(e_rd));
      check($sformatf("%s k%0d rsp_valid", tag, k), 32'(o_rv),   32'(at_rsp));
      check($sformatf("%s k%0d rsp_err", tag, k),   32'(o_rerr), 32'(at_rsp & err));
      check($sformatf("%s k%0d rsp_idx", tag, k),   32'(o_ridx), at_rsp ? 32'(idx) : 32'd0);
      check($sformatf("%s k%0d rsp_tap", tag, k),   32'(o_rtap), at_rsp ? 32'(exp_tap) : 32'd0);
      check($sformatf("%s k%0d busy", tag, k),      32'(o_busy), 32'(k <= rsp_k));
      check($sformatf("%s k%0d ready", tag, k),     32'(o_ready), 32'(k > rsp_k));
   endtask

   task automatic run_cmd(input string tag, input logic s, input logic [1:0] op,
                          input logic [4:0] idx, input logic exp_err,
                          input logic [5:0] exp_tap, input int rsp_k);
      int waited;
      @(negedge clk);
      sel       = s;
      cmd_op    = op;
      cmd_idx   = idx;
      cmd_valid = 1'b1;
      waited    = 0;
      while (o_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (o_ready !== 1'b1) begin
         check($sformatf("%s accept_timeout ready", tag), 32'(o_ready), 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 1; k <= rsp_k + 1; k++) begin
         if (k > 1) @(negedge clk);
         check_cycle(tag, k, op, idx, exp_err, rsp_k, exp_tap);
      end
   endtask

   typedef struct {
      logic       s;
      logic [1:0] op;
      logic [4:0] idx;
      logic [5:0] tap;
      logic       exp_err;
      logic [5:0] exp_tap;
      int         exp_rsp_k;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            sel   op     idx     tap    err   exp_tap rsp_k
      vecs[0]  = '{1'b0, 2'd1, 5'd7,  6'h00, 1'b0, 6'h00, 5};  // INC lane 7
      vecs[1]  = '{1'b0, 2'd3, 5'd19, 6'h2A, 1'b0, 6'h2A, 4};  // READ top lane
      vecs[2]  = '{1'b0, 2'd2, 5'd0,  6'h00, 1'b0, 6'h00, 5};  // DEC lane 0
      vecs[3]  = '{1'b0, 2'd0, 5'd19, 6'h00, 1'b0, 6'h00, 4};  // LOAD lane 19
      vecs[4]  = '{1'b0, 2'd3, 5'd5,  6'h15, 1'b0, 6'h15, 4};  // READ lane 5
      vecs[5]  = '{1'b0, 2'd1, 5'd20, 6'h00, 1'b1, 6'h00, 1};  // first missing lane
      vecs[6]  = '{1'b0, 2'd3, 5'd31, 6'h00, 1'b1, 6'h00, 1};  // max index
      vecs[7]  = '{1'b0, 2'd0, 5'd12, 6'h00, 1'b0, 6'h00, 4};  // LOAD lane 12
      vecs[8]  = '{1'b1, 2'd1, 5'd3,  6'h00, 1'b1, 6'h00, 1};  // masked-off lane
      vecs[9]  = '{1'b1, 2'd0, 5'd25, 6'h00, 1'b1, 6'h00, 1};  // beyond range
      vecs[10] = '{1'b1, 2'd0, 5'd14, 6'h00, 1'b0, 6'h00, 4};  // enabled lane
      vecs[11] = '{1'b1, 2'd3, 5'd16, 6'h00, 1'b1, 6'h00, 1};  // masked-off lane
      vecs[12] = '{1'b1, 2'd3, 5'd0,  6'h3F, 1'b0, 6'h3F, 4};  // READ lane 0

      rst       = 1'b0;
      sel       = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_idx   = 5'd7;
      tap_bus   = '0;

      // Reset held with a pending request: nothing accepted, all quiet.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset c%0d ready", i),  32'(o_ready),  32'd0);
         check($sformatf("reset c%0d busy", i),   32'(o_busy),   32'd0);
         check($sformatf("reset c%0d buses", i),  32'(o_incdec | o_ld | o_adj | o_rd), 32'd0);
         check($sformatf("reset c%0d rsp", i),    32'({o_rv, o_rerr, o_ridx, o_rtap}), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      check("post_reset ready", 32'(o_ready), 32'd1);
      check("post_reset busy",  32'(o_busy),  32'd0);
      cmd_valid = 1'b0;

      // Table-driven single commands.
      for (int v = 0; v < 13; v++) begin
         for (int i = 0; i < 20; i++) tap_bus[i*6 +: 6] = 6'(i * 7 + 3);
         if (vecs[v].idx < 5'd20) tap_bus[vecs[v].idx*6 +: 6] = vecs[v].tap;
         run_cmd($sformatf("vec%0d", v), vecs[v].s, vecs[v].op, vecs[v].idx,
                 vecs[v].exp_err, vecs[v].exp_tap, vecs[v].exp_rsp_k);
      end

      // DEC lane 4 aborted by reset after the adjust pulse.
      @(negedge clk);
      sel       = 1'b0;
      cmd_op    = 2'd2;
      cmd_idx   = 5'd4;
      cmd_valid = 1'b1;
      check("abort pre ready", 32'(o_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("abort k1 busy", 32'(o_busy), 32'd1);
      @(negedge clk);
      check("abort k2 adj", 32'(o_adj), 32'h10);
      rst = 1'b0;
      @(negedge clk);
      check("abort k3 buses", 32'(o_incdec | o_ld | o_adj | o_rd), 32'd0);
      check("abort k3 rsp_valid", 32'(o_rv), 32'd0);
      check("abort k3 busy", 32'(o_busy), 32'd0);
      check("abort k3 ready", 32'(o_ready), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("abort quiet c%0d rsp_valid", i), 32'(o_rv), 32'd0);
      end
      run_cmd("after_abort", 1'b0, 2'd0, 5'd0, 1'b0, 6'h00, 4);

      // Back-to-back LOADs with cmd_valid held throughout.
      @(negedge clk);
      sel       = 1'b0;
      cmd_op    = 2'd0;
      cmd_idx   = 5'd1;
      cmd_valid = 1'b1;
      check("b2b pre ready", 32'(o_ready), 32'd1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) cmd_idx = 5'd2;
         check($sformatf("b2b k%0d ld", k), 32'(o_ld),
               (k == 1) ? 32'h2 : (k == 6) ? 32'h4 : 32'h0);
         check($sformatf("b2b k%0d ld_onehot0", k), 32'($onehot0(o_ld)), 32'd1);
         check($sformatf("b2b k%0d rsp_valid", k), 32'(o_rv), 32'(k == 4 || k == 9));
         check($sformatf("b2b k%0d rsp_idx", k), 32'(o_ridx),
               (k == 4) ? 32'd1 : (k == 9) ? 32'd2 : 32'd0);
         check($sformatf("b2b k%0d ready", k), 32'(o_ready), 32'(k == 5 || k == 10));
         if (k == 6) cmd_valid = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
